// File: rtl/inv_shift_rows_stage.sv
// AES InvShiftRows stage. The transform is applied on entry, and results are held in a 2-entry skid FIFO.
// Defining INV_SR_ADD_ROUND_KEY_EN adds a round_key_in port; the stored word is then InvShiftRows(state_in ^ round_key_in).
module inv_shift_rows_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
`ifdef INV_SR_ADD_ROUND_KEY_EN
  input  logic [127:0] round_key_in,
`endif
  input  logic         clear,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  // Byte (row r, col c) sits at index 4*c + r, counting from the MSB.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        r[127 - 8*(4*((col + row) % 4) + row) -: 8] = s[127 - 8*(4*col + row) -: 8];
      end
    end
    return r;
  endfunction

  logic [127:0] mem [2];
  logic [1:0]   count, count_next;
  logic         wr_ptr, wr_next;
  logic         rd_ptr, rd_next;
  logic [127:0] head_q, head_next;
  logic [127:0] push_word;
  logic         do_push, do_pop;

`ifdef INV_SR_ADD_ROUND_KEY_EN
  assign push_word = inv_shift_rows(state_in ^ round_key_in);
`else
  assign push_word = inv_shift_rows(state_in);
`endif

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign state_out = head_q;

  // The next head word is precomputed so that state_out comes straight from a register.
  always_comb begin
    do_push    = in_valid && in_ready && !clear;
    do_pop     = out_valid && out_ready && !clear;
    count_next = count;
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    head_next  = '0;
    if (clear) begin
      count_next = 2'd0;
      wr_next    = 1'b0;
      rd_next    = 1'b0;
    end else begin
      if (do_push) wr_next = ~wr_ptr;
      if (do_pop)  rd_next = ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count_next = count + 2'd1;
        2'b01:   count_next = count - 2'd1;
        default: count_next = count;
      endcase
    end
    if (count_next == 2'd0)
      head_next = '0;
    else if (do_push && (wr_ptr == rd_next))
      head_next = push_word;
    else
      head_next = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      head_q <= '0;
    end else begin
      count  <= count_next;
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      head_q <= head_next;
    end
  end

  // Entry storage is left unreset; count and the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

endmodule

// File: tb/tb_inv_shift_rows_stage.sv
// Self-checking bench for inv_shift_rows_stage: directed scenarios plus random traffic against a queue model.
// When INV_SR_ADD_ROUND_KEY_EN is defined, the bench also drives round_key_in.
module tb_inv_shift_rows_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] round_key = '0;
  logic         clear = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [127:0] exp_q[$];

  inv_shift_rows_stage dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .state_in(state_in),
`ifdef INV_SR_ADD_ROUND_KEY_EN
    .round_key_in(round_key),
`endif
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  // Reference: unpack the word into a 4x4 grid, rotate each row r right by r, then repack.
  function automatic logic [127:0] ref_isr(input logic [127:0] w);
    logic [7:0]   s [4][4];
    logic [7:0]   o [4][4];
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        s[rr][c] = w[127 - 8*(4*c + rr) -: 8];
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        o[rr][(c + rr) % 4] = s[rr][c];
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++)
        r = {r[119:0], o[rr][c]};
    return r;
  endfunction

  function automatic logic [127:0] ref_word(input logic [127:0] st, input logic [127:0] key);
`ifdef INV_SR_ADD_ROUND_KEY_EN
    return ref_isr(st ^ key);
`else
    return ref_isr(st);
`endif
  endfunction

  function automatic logic [127:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : 128'd0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Advance one clock edge and update the model with the handshake seen at that edge.
  task automatic tick();
    bit push, pop;
    logic [127:0] w;
    push = in_valid && (exp_q.size() < 2) && !clear && !rst;
    pop  = out_ready && (exp_q.size() > 0) && !clear && !rst;
    w    = ref_word(state_in, round_key);
    @(posedge clk);
    #1;
    if (rst || clear) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; state_in = rand128(); out_ready = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total_cnt++; if (state_out !== 128'd0) $display("[TB] FAIL reset_state_out got %h want 0", state_out); else pass_cnt++;
  endtask

  task automatic test_vector();
    round_key = '0;
    in_valid = 1'b1; out_ready = 1'b1; state_in = 128'h00112233445566778899aabbccddeeff;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b1) $display("[TB] FAIL vector_valid got %b want 1", out_valid); else pass_cnt++;
    total_cnt++; if (state_out !== 128'h00ddaa774411eebb885522ffcc996633)
      $display("[TB] FAIL vector_data got %h want 00ddaa774411eebb885522ffcc996633", state_out); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL vector_drain got %b want 0", out_valid); else pass_cnt++;
`ifdef INV_SR_ADD_ROUND_KEY_EN
    round_key = 128'h00112233445566778899aabbccddeeff;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total_cnt++; if (state_out !== 128'd0) $display("[TB] FAIL key_cancel got %h want 0", state_out); else pass_cnt++;
    tick();
    round_key = '0;
`endif
  endtask

  task automatic test_full();
    logic [127:0] a, b;
    a = rand128(); b = rand128();
    out_ready = 1'b0; in_valid = 1'b1;
    state_in = a; tick();
    state_in = b; tick();
    total_cnt++; if (in_ready !== 1'b0) $display("[TB] FAIL full_in_ready got %b want 0", in_ready); else pass_cnt++;
    state_in = rand128(); tick();
    in_valid = 1'b0; tick();
    total_cnt++; if (state_out !== ref_word(a, round_key)) $display("[TB] FAIL full_hold got %h want %h", state_out, ref_word(a, round_key)); else pass_cnt++;
    out_ready = 1'b1; tick();
    total_cnt++; if (state_out !== ref_word(b, round_key)) $display("[TB] FAIL full_second got %h want %h", state_out, ref_word(b, round_key)); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("[TB] FAIL full_ready_rise got %b want 1", in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL full_third_ignored got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [127:0] words [8];
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      words[i] = rand128();
      state_in = words[i];
      tick();
      total_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || state_out !== ref_word(words[i], round_key))
        $display("[TB] FAIL b2b_word%0d got v=%b r=%b %h want v=1 r=1 %h", i, out_valid, in_ready, state_out, ref_word(words[i], round_key));
      else pass_cnt++;
    end
    in_valid = 1'b0; tick();
  endtask

  task automatic test_clear();
    out_ready = 1'b0; in_valid = 1'b1;
    state_in = rand128(); tick();
    state_in = rand128(); tick();
    clear = 1'b1; state_in = rand128(); tick();
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== 128'd0)
      $display("[TB] FAIL clear_flush got v=%b r=%b %h want v=0 r=1 0", out_valid, in_ready, state_out); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0) $display("[TB] FAIL clear_no_word got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    state_in = rand128(); tick();
    state_in = rand128(); tick();
    out_ready = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || state_out !== 128'd0)
      $display("[TB] FAIL reset_mid got v=%b r=%b %h want v=0 r=1 0", out_valid, in_ready, state_out); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 31) == 0);
      state_in  = rand128();
`ifdef INV_SR_ADD_ROUND_KEY_EN
      round_key = rand128();
`endif
      tick();
      total_cnt++;
      if (out_valid !== (exp_q.size() > 0) || in_ready !== (exp_q.size() < 2) || state_out !== exp_head())
        $display("[TB] FAIL random_cycle%0d got v=%b r=%b %h want v=%b r=%b %h", i, out_valid, in_ready, state_out,
                 exp_q.size() > 0, exp_q.size() < 2, exp_head());
      else pass_cnt++;
    end
    in_valid = 1'b0; clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vector();
    test_full();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_stage.md
INV_SHIFT_ROWS_STAGE -- requirements
Module: inv_shift_rows_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with clock `clk` and reset `rst`.
REQ-002 The block SHALL have no parameters; width is fixed at 128 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream presents a state word.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 state_in  input  128  AES state word, column-major; byte0 = [127:120] = s[0][0], byte1 = s[1][0], ..., byte15 = [7:0] = s[3][3].
REQ-008 clear  input  1  synchronous flush of buffered words.
REQ-009 out_valid  output  1  state_out holds a valid word for inv_sub_bytes.
REQ-010 out_ready  input  1  downstream consumes the word this cycle.
REQ-011 state_out  output  128  InvShiftRows result of the head entry, same byte order as state_in.

Function
REQ-012 A push SHALL occur on a rising edge when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-013 The transform SHALL be InvShiftRows, computed before storage: out s[r][(c+r) mod 4] = in s[r][c] for rows r = 0..3 and columns c = 0..3.
REQ-014 Storage SHALL be a 2-entry FIFO (skid buffer) with a 2-bit count (0..2), a 1-bit write pointer and a 1-bit read pointer; both pointers wrap 1 -> 0.
REQ-015 Latency SHALL be one cycle: a word pushed at edge N appears on state_out with out_valid = 1 after edge N.
REQ-016 in_ready SHALL equal (count < 2) and SHALL depend only on registered state, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count > 0); state_out SHALL be the entry at the read pointer, registered and glitch-free.
REQ-018 Count = 0 with a push SHALL give count = 1; a pop request while count = 0 SHALL have no effect.
REQ-019 Count = 1 with a simultaneous push and pop SHALL keep count = 1, advance both pointers and present the new word next cycle.
REQ-020 Count = 2: in_ready = 0 and pushes SHALL be ignored; a pop SHALL give count = 1, and in_ready SHALL rise the following cycle.
REQ-021 While out_valid = 1 and out_ready = 0, state_out SHALL be held stable.
REQ-022 clear = 1 SHALL set count and both pointers to 0 at the next edge.
  - A push in the same cycle as clear SHALL be discarded.
  - clear SHALL take precedence over push and pop.
REQ-023 Entry contents SHALL need no reset; state_out SHALL read 0 while count = 0.

Reset
REQ-024 With rst = 1 at a rising edge, the block SHALL set count = 0 and both pointers = 0.
  - Outputs after that edge SHALL be in_ready = 1, out_valid = 0, state_out = 0.
REQ-025 Reset mid-transfer SHALL discard all buffered words; rst SHALL take precedence over clear, push and pop.

Configuration
REQ-026 Macro INV_SR_ADD_ROUND_KEY_EN defined SHALL add port round_key_in (input, 128) and store InvShiftRows(state_in XOR round_key_in).
  - round_key_in SHALL be sampled with the push.
REQ-027 Macro INV_SR_ADD_ROUND_KEY_EN undefined SHALL omit round_key_in and store InvShiftRows(state_in) only.

Verification
REQ-028 Reset, then push 00112233445566778899aabbccddeeff with out_ready = 1 -> next cycle out_valid = 1 and state_out = 00ddaa774411eebb885522ffcc996633.
REQ-029 With out_ready = 0, push A then B -> count = 2 and in_ready = 0.
  - A third push is ignored.
  - Release out_ready -> A then B on consecutive cycles; B appears unchanged.
REQ-030 Continuous in_valid = out_ready = 1 for 8 words -> one word out per cycle in order, pointers wrap, count stays 1.
REQ-031 Full buffer, assert clear together with a push -> next cycle out_valid = 0, in_ready = 1 and no output of any word.
REQ-032 With the macro defined, round_key_in = state_in = 00112233445566778899aabbccddeeff -> state_out = 0 (all zeros).
REQ-033 Assert rst while count = 2 and out_ready = 1 -> next cycle out_valid = 0, in_ready = 1, state_out = 0.
